// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the icache/dcache memory port arbiter.
package cache_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_LINE_W = 256;
  localparam int unsigned DEF_CNT_W  = 32;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
  typedef enum logic {ICACHE, DCACHE} requester_t;
  typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between icache and dcache.
// Whole-line transactions are serialized; a one-cycle DONE gap follows every response.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LINE_W = DEF_LINE_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  // icache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // dcache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // adaptor side
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  // statistics
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  arb_state_t  state_q;
  requester_t  last_grant_q;
  mem_op_t     op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] data_q;
  logic [CNT_W-1:0]  i_cnt_q;
  logic [CNT_W-1:0]  d_cnt_q;

  logic i_pend;
  logic d_pend;
  logic grant_i;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;
  // On a tie the requester that was not served last wins.
  assign grant_i = i_pend & (~d_pend | (last_grant_q == DCACHE));

  // Arbitration FSM with request latches and completion counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= ICACHE;
      op_q         <= OP_READ;
      addr_q       <= '0;
      data_q       <= '0;
      i_cnt_q      <= '0;
      d_cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q      <= SERVE_I;
            last_grant_q <= ICACHE;
            op_q         <= OP_READ;
            addr_q       <= i_address;
          end else if (d_pend) begin
            state_q      <= SERVE_D;
            last_grant_q <= DCACHE;
            // A simultaneous read and write resolves to the write.
            op_q         <= d_write ? OP_WRITE : OP_READ;
            addr_q       <= d_address;
            data_q       <= d_wdata;
          end
        end
        SERVE_I: begin
          if (pmem_resp) begin
            state_q <= DONE;
            i_cnt_q <= i_cnt_q + CNT_W'(1);
          end
        end
        SERVE_D: begin
          if (pmem_resp) begin
            state_q <= DONE;
            d_cnt_q <= d_cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic serving;
  assign serving = (state_q == SERVE_I) | (state_q == SERVE_D);

  // Memory request decoded purely from registered state, so it ignores requester inputs.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    if (serving) begin
      pmem_address = addr_q;
    end
    if (state_q == SERVE_I) begin
      pmem_read = 1'b1;
    end
    if (state_q == SERVE_D) begin
      pmem_read  = (op_q == OP_READ);
      pmem_write = (op_q == OP_WRITE);
      pmem_wdata = data_q;
    end
  end

  // Responses pass straight through from the adaptor in the completion cycle.
  always_comb begin
    i_resp  = (state_q == SERVE_I) & pmem_resp;
    d_resp  = (state_q == SERVE_D) & pmem_resp;
    i_rdata = i_resp ? pmem_rdata : '0;
    d_rdata = d_resp ? pmem_rdata : '0;
  end

  assign i_grant_cnt = i_cnt_q;
  assign d_grant_cnt = d_cnt_q;

`ifndef SYNTHESIS
  // The dcache must never ask for a read and a writeback at once.
  d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write))
    else $error("d_read and d_write asserted together");
`endif

endmodule
